// File: rtl/prog_loader_pkg.sv
// Shared command codes and loader state encoding for prog_loader and the
// simulation/FPGA tops that drive it.
package prog_loader_pkg;

  localparam logic [7:0] CmdImem  = 8'h01;
  localparam logic [7:0] CmdDmem  = 8'h02;
  localparam logic [7:0] CmdStart = 8'h03;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLen,
    StData,
    StCsum,
    StDone
  } ldr_state_e;

endpackage

// File: rtl/ldr_word_asm.sv
// Little-endian byte-to-word assembler: the first byte received lands in the
// least significant position. word_o/done_o describe the word completed by this byte.
module ldr_word_asm #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         valid_i,
  input  logic [7:0]   byte_i,
  output logic [W-1:0] word_o,
  output logic         done_o
);

  localparam int unsigned NumBytes = W / 8;
  localparam int unsigned CntW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;

  logic [W-1:0]    sh_q, sh_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    done_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (valid_i) begin
      sh_d   = (sh_q >> 8) | (W'(byte_i) << (W - 8));
      done_o = (cnt_q == CntW'(NumBytes - 1));
      cnt_d  = done_o ? '0 : cnt_q + 1'b1;
    end
    word_o = sh_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed, checksummed UART program loader: decodes IMEM/DMEM/START frames,
// issues memory writes and holds the core in reset until a valid START.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_LEN    = 32,
  parameter int unsigned IMEM_W      = 128,
  parameter int unsigned IMEM_AW     = 9,
  parameter int unsigned DMEM_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                clk,
  input  logic                reset_x,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                imem_we,
  output logic [IMEM_AW-1:0]  imem_addr,
  output logic [IMEM_W-1:0]   imem_wdata,
  output logic                dmem_we,
  output logic [ADDR_LEN-1:0] dmem_addr,
  output logic [DMEM_W-1:0]   dmem_wdata,
  output logic                loading,
  output logic                done,
  output logic                err
);

  localparam int unsigned IBytes = IMEM_W / 8;
  localparam int unsigned DBytes = DMEM_W / 8;
  localparam int unsigned IShift = $clog2(IBytes);
  localparam int unsigned TmoW   = $clog2(TIMEOUT_CYC + 1);

  ldr_state_e          state_q, state_d;
  logic                is_imem_q, is_imem_d, is_start_q, is_start_d;
  logic [1:0]          fld_cnt_q, fld_cnt_d;
  logic [23:0]         fld_q, fld_d;
  logic [ADDR_LEN-1:0] baddr_q, baddr_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          csum_q, csum_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic                rx_ready_q;
  logic                imem_we_q, imem_we_d, dmem_we_q, dmem_we_d;
  logic [IMEM_AW-1:0]  imem_addr_q, imem_addr_d;
  logic [IMEM_W-1:0]   imem_wdata_q, imem_wdata_d;
  logic [ADDR_LEN-1:0] dmem_addr_q, dmem_addr_d;
  logic [DMEM_W-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic                loading_q, loading_d, done_q, done_d, err_q, err_d;

  logic                accept, in_frame, asm_clr, i_done, d_done;
  logic [IMEM_W-1:0]   i_word;
  logic [DMEM_W-1:0]   d_word;
  logic [15:0]         len_in;

  assign accept   = rx_valid & rx_ready_q;
  assign in_frame = (state_q == StAddr) || (state_q == StLen) ||
                    (state_q == StData) || (state_q == StCsum);
  assign asm_clr  = (state_q != StData);
  assign len_in   = {rx_data, fld_q[7:0]};

  ldr_word_asm #(.W(IMEM_W)) u_imem_asm (
    .clk_i   (clk),
    .rst_ni  (reset_x),
    .clr_i   (asm_clr),
    .valid_i (accept && (state_q == StData) && is_imem_q),
    .byte_i  (rx_data),
    .word_o  (i_word),
    .done_o  (i_done)
  );

  ldr_word_asm #(.W(DMEM_W)) u_dmem_asm (
    .clk_i   (clk),
    .rst_ni  (reset_x),
    .clr_i   (asm_clr),
    .valid_i (accept && (state_q == StData) && !is_imem_q),
    .byte_i  (rx_data),
    .word_o  (d_word),
    .done_o  (d_done)
  );

  always_comb begin
    state_d      = state_q;
    is_imem_d    = is_imem_q;
    is_start_d   = is_start_q;
    fld_cnt_d    = fld_cnt_q;
    fld_d        = fld_q;
    baddr_d      = baddr_q;
    len_d        = len_q;
    csum_d       = accept ? csum_q + rx_data : csum_q;
    tmo_d        = (in_frame && !accept) ? tmo_q + 1'b1 : '0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    done_d       = done_q;
    err_d        = err_q;

    case (state_q)
      StIdle: if (accept) begin
        csum_d     = rx_data;
        fld_cnt_d  = '0;
        is_imem_d  = (rx_data == CmdImem);
        is_start_d = (rx_data == CmdStart);
        if (rx_data == CmdImem || rx_data == CmdDmem) state_d = StAddr;
        else if (rx_data == CmdStart)                 state_d = StCsum;
        else                                          err_d   = 1'b1;
      end
      StAddr: if (accept) begin
        fld_cnt_d = fld_cnt_q + 1'b1;
        if (fld_cnt_q == 2'd3) begin
          baddr_d = ADDR_LEN'({rx_data, fld_q});
          state_d = StLen;
        end else begin
          fld_d[8*fld_cnt_q +: 8] = rx_data;
        end
      end
      StLen: if (accept) begin
        if (fld_cnt_q == 2'd0) begin
          fld_d[7:0] = rx_data;
          fld_cnt_d  = 2'd1;
        end else begin
          len_d     = len_in;
          fld_cnt_d = '0;
          state_d   = (len_in == 16'd0) ? StCsum : StData;
        end
      end
      StData: if (i_done || d_done) begin
        if (is_imem_q) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = IMEM_AW'(baddr_q >> IShift);
          imem_wdata_d = i_word;
          baddr_d      = baddr_q + ADDR_LEN'(IBytes);
        end else begin
          dmem_we_d    = 1'b1;
          dmem_addr_d  = baddr_q;
          dmem_wdata_d = d_word;
          baddr_d      = baddr_q + ADDR_LEN'(DBytes);
        end
        len_d = len_q - 1'b1;
        if (len_q == 16'd1) state_d = StCsum;
      end
      StCsum: if (accept) begin
        if (csum_d != 8'd0) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (is_start_q) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StIdle;
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase

    // The last idle cycle of the window aborts the frame.
    if (in_frame && !accept && tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
      err_d   = 1'b1;
      state_d = StIdle;
      tmo_d   = '0;
    end
    loading_d = ~done_d;
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q      <= StIdle;
      is_imem_q    <= 1'b0;
      is_start_q   <= 1'b0;
      fld_cnt_q    <= '0;
      fld_q        <= '0;
      baddr_q      <= '0;
      len_q        <= '0;
      csum_q       <= '0;
      tmo_q        <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      loading_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_imem_q    <= is_imem_d;
      is_start_q   <= is_start_d;
      fld_cnt_q    <= fld_cnt_d;
      fld_q        <= fld_d;
      baddr_q      <= baddr_d;
      len_q        <= len_d;
      csum_q       <= csum_d;
      tmo_q        <= tmo_d;
      rx_ready_q   <= 1'b1;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      loading_q    <= loading_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign loading    = loading_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomised frame stimulus with a byte-level reference model; expected memory
// writes are queued by the driver and popped by an independent write monitor.
module tb_prog_loader;

  logic         clk = 1'b0;
  logic         reset_x;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         imem_we, dmem_we;
  logic [8:0]   imem_addr;
  logic [127:0] imem_wdata;
  logic [31:0]  dmem_addr, dmem_wdata;
  logic         loading, done, err;

  typedef struct {
    bit           imem;
    logic [31:0]  addr;
    logic [127:0] data;
  } wr_t;

  wr_t          exp_q[$];
  logic [127:0] payload[16];
  bit           exp_err, exp_done;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  prog_loader #(
    .ADDR_LEN    (32),
    .IMEM_W      (128),
    .IMEM_AW     (9),
    .DMEM_W      (32),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk        (clk),
    .reset_x    (reset_x),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .loading    (loading),
    .done       (done),
    .err        (err)
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_x === 1'b1 && (imem_we === 1'b1 || dmem_we === 1'b1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: imem_we=%0b dmem_we=%0b, none expected", imem_we, dmem_we);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (e.imem)
          chk("imem_write", {imem_we, dmem_we, 23'd0, imem_addr, imem_wdata},
              {2'b10, e.addr, e.data});
        else
          chk("dmem_write", {imem_we, dmem_we, dmem_addr, 96'd0, dmem_wdata},
              {2'b01, e.addr, e.data});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (rx_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (rx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_wait: got %0b, expected 1 within 20 cycles", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Reference model: builds the byte stream, predicts writes and sticky flags.
  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr, input int n,
                            input bit bad);
    logic [7:0]  sum, cs;
    logic [31:0] a;
    logic [15:0] nn;
    int          nb;
    bit          model = !exp_done;
    sum = cmd;
    send_byte(cmd);
    if (cmd != 8'h03) begin
      nn = 16'(n);
      for (int k = 0; k < 4; k++) begin
        sum += addr[8*k +: 8];
        send_byte(addr[8*k +: 8]);
      end
      for (int k = 0; k < 2; k++) begin
        sum += nn[8*k +: 8];
        send_byte(nn[8*k +: 8]);
      end
      nb = (cmd == 8'h01) ? 16 : 4;
      a  = addr;
      for (int i = 0; i < n; i++) begin
        if (model) begin
          if (cmd == 8'h01) exp_q.push_back('{1'b1, (a >> 4) & 32'h1FF, payload[i]});
          else              exp_q.push_back('{1'b0, a, {96'd0, payload[i][31:0]}});
        end
        for (int k = 0; k < nb; k++) begin
          sum += payload[i][8*k +: 8];
          send_byte(payload[i][8*k +: 8]);
        end
        a = a + 32'(nb);
      end
    end
    cs = 8'h00 - sum;
    if (bad) cs = cs ^ 8'h5A;
    send_byte(cs);
    if (model) begin
      if (bad) exp_err = 1'b1;
      else if (cmd == 8'h03) exp_done = 1'b1;
    end
  endtask

  task automatic check_flags(input string name);
    chk({name, "_err"}, 160'(err), 160'(exp_err));
    chk({name, "_done"}, 160'(done), 160'(exp_done));
    chk({name, "_loading"}, 160'(loading), 160'(!exp_done));
  endtask

  task automatic rand_payload(input int n);
    for (int i = 0; i < n; i++) payload[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic pulse_reset();
    #2 reset_x = 1'b0;
    #1;
    chk("rst_loading", 160'(loading), 160'd1);
    chk("rst_done", 160'(done), 160'd0);
    chk("rst_err", 160'(err), 160'd0);
    chk("rst_rx_ready", 160'(rx_ready), 160'd0);
    chk("rst_we", {imem_we, dmem_we}, 160'd0);
    exp_err  = 1'b0;
    exp_done = 1'b0;
    repeat (2) @(negedge clk);
    reset_x = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_x  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    exp_err  = 1'b0;
    exp_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rx_ready, done, err, imem_we, dmem_we, loading},
        160'b000001);
    chk("reset_addr_data", {imem_addr, dmem_addr, dmem_wdata}, 160'd0);
    chk("reset_imem_wdata", 160'(imem_wdata), 160'd0);
    reset_x = 1'b1;
    @(negedge clk);
    chk("rx_ready_after_reset", 160'(rx_ready), 160'd1);

    // Directed IMEM and DMEM frames.
    for (int k = 0; k < 16; k++) payload[0][8*k +: 8] = 8'(k);
    send_frame(8'h01, 32'h0000_0010, 1, 1'b0);
    check_flags("imem_frame");
    payload[0] = 128'hDEAD_BEEF;
    payload[1] = 128'h1234_5678;
    send_frame(8'h02, 32'h0000_0020, 2, 1'b0);
    check_flags("dmem_frame");

    // Random valid frames, some straddling the top of the address space.
    for (int f = 0; f < 12; f++) begin
      int          n;
      logic [31:0] a;
      n = $urandom_range(0, 3);
      a = (f % 3 == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      rand_payload(n);
      send_frame(8'($urandom_range(1, 2)), a, n, 1'b0);
    end
    check_flags("random_frames");

    // Bad checksum: writes still land, err latches, a valid frame still decodes.
    rand_payload(2);
    send_frame(8'h02, 32'h0000_0100, 2, 1'b1);
    check_flags("bad_csum");
    rand_payload(1);
    send_frame(8'h02, 32'h0000_0040, 1, 1'b0);
    check_flags("after_bad_csum");
    pulse_reset();

    // Bad command.
    send_byte(8'h7F);
    exp_err = 1'b1;
    check_flags("bad_cmd");
    rand_payload(1);
    send_frame(8'h01, 32'h0000_0230, 1, 1'b0);
    check_flags("after_bad_cmd");
    pulse_reset();

    // Timeout after two address bytes: err only after the 16th idle cycle.
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    repeat (15) @(negedge clk);
    chk("timeout_early", 160'(err), 160'd0);
    @(negedge clk);
    exp_err = 1'b1;
    check_flags("timeout");
    rand_payload(2);
    send_frame(8'h02, 32'h0000_0080, 2, 1'b0);
    check_flags("after_timeout");
    pulse_reset();

    // START, then bytes in DONE are discarded, then reset mid-payload.
    send_byte(8'h03);
    check_flags("start_cmd");
    send_byte(8'hFD);
    exp_done = 1'b1;
    check_flags("start_done");
    send_byte(8'h02);
    for (int k = 0; k < 4; k++) send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    check_flags("done_discard");
    pulse_reset();
    rand_payload(3);
    send_frame(8'h01, 32'h0000_1FF0, 3, 1'b0);
    check_flags("after_reset");

    repeat (4) @(negedge clk);
    chk("pending_writes", 160'(exp_q.size()), 160'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Parametrised program loader for the out-of-order core's simulation and FPGA tops. It accepts a byte stream from a UART receiver and decodes framed, checksummed load commands. It writes wide instruction-memory lines and data-memory words, and holds the core in reset (`loading`) until a valid START frame arrives. It sits between the UART receiver and the imem/dmem write-port muxes, and replaces the fixed-width, unframed loader.

## Interface
Parameters:
- `ADDR_LEN`, 32: byte-address width.
- `IMEM_W`, 128: imem line width in bits; a power-of-two number of bytes.
- `IMEM_AW`, 9: imem line-index width.
- `DMEM_W`, 32: dmem word width in bits; a power-of-two number of bytes.
- `TIMEOUT_CYC`, 1000000: idle cycles allowed inside a frame before it is aborted.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset_x` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte.
- `imem_we` out 1: imem write strobe, one cycle per line.
- `imem_addr` out `IMEM_AW`: imem line index.
- `imem_wdata` out `IMEM_W`: imem line data.
- `dmem_we` out 1: dmem write strobe.
- `dmem_addr` out `ADDR_LEN`: dmem byte address.
- `dmem_wdata` out `DMEM_W`: dmem word data.
- `loading` out 1: hold core in reset.
- `done` out 1: load complete; sticky until reset.
- `err` out 1: sticky error flag (bad command, bad checksum or timeout).

## Operation
Frame format. All multi-byte fields are little-endian.
- `cmd`: 0x01 = IMEM block, 0x02 = DMEM block, 0x03 = START.
- For 0x01/0x02, `cmd` is followed by:
  - addr: 4 bytes, byte address.
  - N: 2 bytes, word count.
  - payload: N words of `IMEM_W/8` or `DMEM_W/8` bytes.
  - csum: 1 byte.
- For START, `cmd` is followed only by the csum byte.
- A frame is valid when the sum of all its bytes, csum included, is 0 mod 256.

States: IDLE, ADDR, LEN, DATA, CSUM, DONE.
- IDLE, cmd byte:
  - 0x01/0x02 → ADDR.
  - 0x03 → CSUM.
  - Any other value → set `err`, stay in IDLE.
- ADDR: after 4 bytes → LEN.
- LEN: after 2 bytes → DATA, or → CSUM if N=0.
- DATA:
  - When a word completes, issue its write and increment the byte address by the word size, modulo 2^`ADDR_LEN`.
  - After the N-th word → CSUM.
- CSUM:
  - Sum ≠ 0 → set `err`, go to IDLE. Writes already issued are not undone.
  - Sum = 0 on START → DONE.
  - Sum = 0 on IMEM/DMEM → IDLE.
- DONE: all further bytes are accepted and discarded. `done`=1 and `loading`=0 until reset.

Addressing:
- `imem_addr` = byte address >> log2(`IMEM_W/8`), truncated to `IMEM_AW` bits (wraps).
- `dmem_addr` = the full byte address; the top level performs the word shift.

Timeout:
- A counter runs in ADDR, LEN, DATA and CSUM, and clears on every accepted byte.
- When `TIMEOUT_CYC` cycles pass with no accepted byte: set `err`, go to IDLE.

## Timing
Reset values (while `reset_x`=0):
- `loading`=1.
- `rx_ready`, `done`, `err`, `imem_we`, `dmem_we` = 0.
- Address and data outputs = 0.
- State = IDLE.

Handshake:
- A byte transfers when `rx_valid & rx_ready` at a rising edge of `clk`.
- `rx_ready` goes to 1 on the first edge after `reset_x` is released and stays 1.

Latencies:
- Write strobe asserts for exactly one cycle, in the cycle after the last byte of the word is accepted. Address and data are valid with the strobe.
- `done` rises and `loading` falls in the cycle after the valid START csum byte.
- `err` rises in the cycle after the offending byte, or after the final timeout cycle.

Reset mid-frame: asynchronous clear of all state; `loading` returns to 1 immediately.

All outputs are registered.

## Structure
- Command codes and state encoding go in `constants.vh` as `define`s shared with the tops.
- Sub-module `ldr_word_asm`:
  - Parametrised byte-to-word shift register with a byte counter and a `word_done` pulse.
  - Instantiated twice, once for `IMEM_W` and once for `DMEM_W`; alternatively one instance at `IMEM_W` with a runtime word-size select.
- Checksum accumulator and timeout counter live in `prog_loader`. The timeout counter width is $clog2(`TIMEOUT_CYC`+1).

## Test plan
- **IMEM write:** IMEM frame, addr 0x00000010, N=1, payload bytes 0x00..0x0F, correct csum → one `imem_we` pulse, `imem_addr`=1, `imem_wdata`=0x0F0E…0100; `err`=0.
- **DMEM writes:** DMEM frame, addr 0x20, N=2, words 0xDEADBEEF and 0x12345678 → `dmem_we` pulses at `dmem_addr` 0x20 then 0x24 with those data.
- **Bad checksum:** wrong csum on any frame → `err`=1, `loading` stays 1; a following valid DMEM frame still writes correctly.
- **Bad command:** cmd 0x7F → `err`=1, state IDLE, no write strobes.
- **Timeout:** `TIMEOUT_CYC`=16; stall 16 cycles after 2 addr bytes → `err`=1; a following valid frame is decoded from its cmd byte.
- **START and reset:** START frame 0x03 0xFD → next cycle `done`=1, `loading`=0; then pulse `reset_x` low mid-payload of a new frame → `loading`=1, `done`=0, `err`=0 immediately.
